// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
package piso_pkg;

  typedef enum logic {
    PISO_IDLE  = 1'b0,
    PISO_SHIFT = 1'b1
  } piso_state_e;

  // Width of the bit counter that walks 0..width-1.
  function automatic int piso_cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_if.sv
// Load handshake and serial output bundle of the serializer.
interface piso_if #(
  parameter int WIDTH = 8
);
  logic             pin_valid;
  logic [WIDTH-1:0] pin;
  logic             pin_ready;
  logic             sout;
  logic             sout_valid;
  logic             last;

  modport master (
    output pin_valid, pin,
    input  pin_ready, sout, sout_valid, last
  );

  modport slave (
    input  pin_valid, pin,
    output pin_ready, sout, sout_valid, last
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: valid/ready word load, ce-paced shifting,
// selectable bit order and gapless back-to-back framing.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   ce,
  piso_if.slave  bus
);
  import piso_pkg::*;

  localparam int            CW       = piso_cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[WIDTH-1];
  endfunction

  // Vacated positions fill with zero.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? {1'b0, w[WIDTH-1:1]} : {w[WIDTH-2:0], 1'b0};
  endfunction

  piso_state_e      state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             last_q, last_d;

  logic             at_last;
  logic             pin_ready;
  logic             accept;
  logic [WIDTH-1:0] sreg_shifted;
  logic [CW-1:0]    cnt_inc;

  assign at_last      = (cnt_q == CNT_LAST);
  assign pin_ready    = (state_q == PISO_IDLE) || ((state_q == PISO_SHIFT) && at_last && ce);
  assign accept       = bus.pin_valid && pin_ready;
  assign sreg_shifted = shift_word(sreg_q);
  assign cnt_inc      = cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    cnt_d        = cnt_q;
    sout_d       = sout_q;
    sout_valid_d = sout_valid_q;
    last_d       = last_q;

    // A load can only happen from IDLE or on the final ce tick of a word,
    // so it takes priority over every shift/exit decision.
    if (accept) begin
      state_d      = PISO_SHIFT;
      sreg_d       = bus.pin;
      cnt_d        = '0;
      sout_d       = head_bit(bus.pin);
      sout_valid_d = 1'b1;
      last_d       = 1'b0;
    end else if ((state_q == PISO_SHIFT) && ce) begin
      if (at_last) begin
        state_d      = PISO_IDLE;
        sreg_d       = '0;
        cnt_d        = '0;
        sout_d       = 1'b0;
        sout_valid_d = 1'b0;
        last_d       = 1'b0;
      end else begin
        sreg_d = sreg_shifted;
        cnt_d  = cnt_inc;
        sout_d = head_bit(sreg_shifted);
        last_d = (cnt_inc == CNT_LAST);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= PISO_IDLE;
      sreg_q       <= '0;
      cnt_q        <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      cnt_q        <= cnt_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      last_q       <= last_d;
    end
  end

  assign bus.pin_ready  = pin_ready;
  assign bus.sout       = sout_q;
  assign bus.sout_valid = sout_valid_q;
  assign bus.last       = last_q;

endmodule
